instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the multi-cycle KGP-RISC core. Owns the PC and the instruction register (IR).
//  Drives the instruction-memory request handshake and slices the IR into opcode/func/rs/rt/shamt/imm/label.
//  Opcode/func feed the control_unit; the remaining fields feed the register file and ALU.
//  Accepts PC redirects (branch/jump) from the execute stage and detects HALT and memory timeouts.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  HALT_OPCODE  6'b111111      opcode that stops fetching after it is issued
//  TIMEOUT      16             max cycles in REQ without imem_valid before FAULT (range 1..255)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  imem_req       out  1   instruction-memory read request (level; held until imem_valid)
//  imem_addr      out  32  read address = PC, word aligned
//  imem_valid     in   1   imem_rdata valid this cycle; ignored outside REQ
//  imem_rdata     in   32  instruction word
//  instr_valid    out  1   IR holds an instruction not yet accepted downstream
//  instr_ack      in   1   downstream has consumed the IR; ignored when instr_valid=0
//  redirect_valid in   1   use redirect_pc as next PC; sampled only with instr_ack
//  redirect_pc    in   32  branch/jump target
//  opcode         out  6   IR[31:26]
//  func           out  5   IR[4:0]
//  rs / rt        out  5   IR[25:21] / IR[20:16]
//  shamt          out  5   IR[15:11]
//  imm16          out  16  IR[15:0]
//  label          out  26  IR[25:0]
//  pc_out         out  32  PC of the instruction held in IR
//  pc_plus4       out  32  pc_out + 4, mod 2^32
//  halted         out  1   HALT state reached
//  fault          out  1   sticky: timeout or misaligned redirect
// BEHAVIOUR
//  Reset values: PC=RESET_PC, IR=0, state=IDLE, timeout counter=0. All outputs 0 except imem_addr=RESET_PC.
//  All fields are combinational slices of the registered IR; no other outputs are combinational from inputs.
//  FSM states and transitions:
//   IDLE -> REQ on the first edge after rst deasserts.
//   REQ: imem_req=1, imem_addr=PC, counter increments each cycle.
//    imem_valid=1 -> IR<=imem_rdata, counter<=0, go to ISSUE. Zero-wait memory is legal.
//    counter==TIMEOUT-1 without imem_valid -> FAULT.
//   ISSUE: instr_valid=1, imem_req=0. IR is held stable until instr_ack.
//    On instr_ack:
//     - IR opcode==HALT_OPCODE -> HALT (redirect ignored).
//     - redirect_valid=1 and redirect_pc[1:0]!=0 -> FAULT.
//     - redirect_valid=1 (aligned) -> PC<=redirect_pc, go to REQ.
//     - otherwise -> PC<=PC+4, go to REQ.
//   HALT: halted=1, no requests. Exit only by rst.
//   FAULT: fault=1, no requests. Exit only by rst.
//  Latency: with zero-wait memory, instr_valid rises 2 edges after reset release.
//   Steady state is one instruction per 2 cycles (ack edge -> REQ, valid edge -> ISSUE).
//  PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//  redirect_valid without instr_ack is ignored.
//  imem_valid arriving in ISSUE/HALT/FAULT/IDLE is dropped.
//  rst asserted mid-request: imem_req drops immediately (async); a late imem_valid after reset is ignored until REQ.
// STRUCTURE
//  Shared include isa_defs.vh holds:
//   - IR field bit positions
//   - HALT opcode
//   - FSM state encodings (IDLE=0, REQ=1, ISSUE=2, HALT=3, FAULT=4, 3-bit)
//   - instruction width
//  One sub-module: program_counter (PC register, +4 adder, redirect mux, alignment check).
//  The FSM, timeout counter and IR live in the top level.
// TESTING
//  1 Reset release, memory returns 32'h0400_0005 with 0 wait -> 2nd edge: instr_valid=1, opcode=6'b000001, func=5'b00101, pc_out=0.
//  2 Ack with redirect_valid=0 at PC=0x10 -> next imem_addr=0x14. Ack with redirect_valid=1, redirect_pc=0x40 -> imem_addr=0x40, pc_plus4=0x44 after capture.
//  3 Memory waits 3 cycles -> imem_req stays 1 for 4 cycles, IR captured on the valid cycle. Withholding valid for TIMEOUT cycles -> fault=1, imem_req=0.
//  4 Fetch opcode 6'b111111, ack -> halted=1. imem_req stays 0 for 20 cycles. rst -> PC=RESET_PC, fetch resumes.
//  5 redirect_pc=0x42 with ack -> fault=1. Separately, redirect_valid pulsed while instr_valid=1 and no ack -> PC unchanged.
//  6 PC=0xFFFF_FFFC, ack with no redirect -> imem_addr=0. rst pulsed mid-REQ -> imem_req=0 within the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the KGP-RISC fetch stage: IR field positions,
// instruction width, HALT opcode and FSM state encodings.
package instruction_fetch_unit_pkg;

    localparam int INSTR_W    = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int SHAMT_MSB  = 15;
    localparam int SHAMT_LSB  = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int LABEL_MSB  = 25;
    localparam int LABEL_LSB  = 0;
    localparam int FUNC_MSB   = 4;
    localparam int FUNC_LSB   = 0;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc.sv
// Program counter for the fetch stage: PC register, +4 incrementer,
// redirect mux and redirect alignment check.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_pc_en                 load next PC this edge
//   i_redirect_valid/_pc    take i_redirect_pc instead of PC+4
//   o_pc, o_pc_plus4        current PC and PC+4 (wraps mod 2^32)
//   o_redirect_misaligned   redirect requested to a non-word address
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_en,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_redirect_misaligned
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    assign o_pc                  = r_pc;
    assign o_pc_plus4            = r_pc + 32'd4;
    assign o_redirect_misaligned = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    assign w_pc_next             = i_redirect_valid ? i_redirect_pc : o_pc_plus4;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the multi-cycle KGP-RISC core. Owns the IR and the fetch
// FSM; the PC lives in program_counter.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   o_imem_req, o_imem_addr           instruction-memory read request / address
//   i_imem_valid, i_imem_rdata        memory response
//   o_instr_valid, i_instr_ack        IR handshake with downstream
//   i_redirect_valid, i_redirect_pc   branch/jump target, taken with ack
//   o_opcode .. o_label               slices of the registered IR
//   o_pc_out, o_pc_plus4              PC of the IR instruction and PC+4
//   o_halted, o_fault                 terminal states (exit only by reset)
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int          TIMEOUT     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ack,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_func,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_shamt,
    output logic [15:0] o_imm16,
    output logic [25:0] o_label,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4,
    output logic        o_halted,
    output logic        o_fault
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [INSTR_W-1:0]   r_ir;
    logic [31:0]          r_ir_pc;
    logic [31:0]          r_ir_pc4;
    logic [7:0]           r_tmo_cnt;
    logic                 w_pc_en;
    logic                 w_ir_load;
    logic [31:0]          w_pc;
    logic [31:0]          w_pc_plus4;
    logic                 w_misaligned;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_pc_en               (w_pc_en),
        .i_redirect_valid      (i_redirect_valid),
        .i_redirect_pc         (i_redirect_pc),
        .o_pc                  (w_pc),
        .o_pc_plus4            (w_pc_plus4),
        .o_redirect_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HALT beats a redirect on the same ack, so a HALT followed by a bad
    // target still halts cleanly rather than faulting.
    always_comb begin
        w_state_next = r_state;
        w_pc_en      = 1'b0;
        w_ir_load    = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = ST_REQ;
            ST_REQ: begin
                if (i_imem_valid) begin
                    w_ir_load    = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (i_instr_ack) begin
                    if (r_ir[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                        w_state_next = ST_HALT;
                    end else if (w_misaligned) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_pc_en      = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_HALT:  w_state_next = ST_HALT;
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Counts cycles spent in REQ without a response; cleared everywhere else.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == ST_REQ && !i_imem_valid) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= 8'd0;
        end
    end

    // pc_out/pc_plus4 are captured with the IR so they stay tied to the held
    // instruction while the PC itself moves on to the next fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir     <= '0;
            r_ir_pc  <= 32'd0;
            r_ir_pc4 <= 32'd0;
        end else if (w_ir_load) begin
            r_ir     <= i_imem_rdata;
            r_ir_pc  <= w_pc;
            r_ir_pc4 <= w_pc_plus4;
        end
    end

    assign o_imem_req    = (r_state == ST_REQ);
    assign o_imem_addr   = w_pc;
    assign o_instr_valid = (r_state == ST_ISSUE);
    assign o_halted      = (r_state == ST_HALT);
    assign o_fault       = (r_state == ST_FAULT);

    assign o_opcode   = r_ir[OPCODE_MSB:OPCODE_LSB];
    assign o_func     = r_ir[FUNC_MSB:FUNC_LSB];
    assign o_rs       = r_ir[RS_MSB:RS_LSB];
    assign o_rt       = r_ir[RT_MSB:RT_LSB];
    assign o_shamt    = r_ir[SHAMT_MSB:SHAMT_LSB];
    assign o_imm16    = r_ir[IMM_MSB:IMM_LSB];
    assign o_label    = r_ir[LABEL_MSB:LABEL_LSB];
    assign o_pc_out   = r_ir_pc;
    assign o_pc_plus4 = r_ir_pc4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  opcode;
    logic [4:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] label;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;

    instruction_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_valid     (imem_valid),
        .i_imem_rdata     (imem_rdata),
        .o_instr_valid    (instr_valid),
        .i_instr_ack      (instr_ack),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_opcode         (opcode),
        .o_func           (func),
        .o_rs             (rs),
        .o_rt             (rt),
        .o_shamt          (shamt),
        .o_imm16          (imm16),
        .o_label          (label),
        .o_pc_out         (pc_out),
        .o_pc_plus4       (pc_plus4),
        .o_halted         (halted),
        .o_fault          (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  fn;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_prev_valid = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Scoreboard monitor: each new instruction presented by the DUT is
    // compared against the oldest expected entry.
    always @(negedge clk) begin
        if (instr_valid && !mon_prev_valid) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_instr");
            end else begin
                mon_e = sb_q.pop_front();
                check("opcode",   {26'd0, opcode}, {26'd0, mon_e.op});
                check("func",     {27'd0, func},   {27'd0, mon_e.fn});
                check("rs",       {27'd0, rs},     {27'd0, mon_e.instr[25:21]});
                check("rt",       {27'd0, rt},     {27'd0, mon_e.instr[20:16]});
                check("shamt",    {27'd0, shamt},  {27'd0, mon_e.instr[15:11]});
                check("imm16",    {16'd0, imm16},  {16'd0, mon_e.instr[15:0]});
                check("label",    {6'd0, label},   {6'd0, mon_e.instr[25:0]});
                check("pc_out",   pc_out,          mon_e.pc);
                check("pc_plus4", pc_plus4,        mon_e.pc4);
            end
        end
        mon_prev_valid = instr_valid;
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] addr, input int waits,
                         input logic [5:0] op, input logic [4:0] fn, input logic [31:0] pc4);
        bit ok;
        wait_req(ok);
        if (!ok) begin
            fail_now("wait_imem_req");
            return;
        end
        check("imem_addr", addr, addr == imem_addr ? addr : imem_addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        sb_q.push_back(exp_t'{instr: instr, op: op, fn: fn, pc: addr, pc4: pc4});
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        check("req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic ack(input logic rv, input logic [31:0] rpc);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("wait_instr_valid");
            return;
        end
        instr_ack      = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_valid = 1'b0;
        instr_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hits;
        bit  ok;
        rst            = 1'b1;
        imem_valid     = 1'b1;
        imem_rdata     = 32'h0400_0005;
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state (imem_valid held high in reset/IDLE must be dropped)
        check("rst_imem_req",   {31'd0, imem_req},    32'd0);
        check("rst_instr_valid",{31'd0, instr_valid}, 32'd0);
        check("rst_imem_addr",  imem_addr,            32'd0);
        check("rst_opcode",     {26'd0, opcode},      32'd0);
        check("rst_label",      {6'd0, label},        32'd0);
        check("rst_pc_plus4",   pc_plus4,             32'd0);
        check("rst_halted",     {31'd0, halted},      32'd0);
        check("rst_fault",      {31'd0, fault},       32'd0);

        // Zero-wait first fetch: valid on the 2nd edge after release
        sb_q.push_back(exp_t'{instr: 32'h0400_0005, op: 6'h01, fn: 5'h05, pc: 32'h0, pc4: 32'h4});
        rst = 1'b0;
        @(negedge clk);
        check("edge1_req",   {31'd0, imem_req},    32'd1);
        check("edge1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("edge2_valid", {31'd0, instr_valid}, 32'd1);
        imem_valid = 1'b0;
        imem_rdata = 32'd0;

        // Sequential fetches up to PC=0x10, then a 3-wait fetch at 0x14
        ack(1'b0, 32'd0);
        fetch(32'h8C22_0010, 32'h04, 0, 6'h23, 5'h10, 32'h08);
        ack(1'b0, 32'd0);
        fetch(32'h0043_1820, 32'h08, 0, 6'h00, 5'h00, 32'h0C);
        ack(1'b0, 32'd0);
        fetch(32'h1234_5678, 32'h0C, 0, 6'h04, 5'h18, 32'h10);
        ack(1'b0, 32'd0);
        fetch(32'hDEAD_BEEF, 32'h10, 0, 6'h37, 5'h0F, 32'h14);
        ack(1'b0, 32'd0);
        fetch(32'hA5A5_5A5A, 32'h14, 3, 6'h29, 5'h1A, 32'h18);

        // Aligned redirect to 0x40
        ack(1'b1, 32'h40);
        fetch(32'h0000_0003, 32'h40, 0, 6'h00, 5'h03, 32'h44);

        // Redirect without ack is ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        check("noack_valid", {31'd0, instr_valid}, 32'd1);
        check("noack_pc",    imem_addr,            32'h40);

        // PC wrap
        ack(1'b1, 32'hFFFF_FFFC);
        fetch(32'h3C01_FFFF, 32'hFFFF_FFFC, 0, 6'h0F, 5'h1F, 32'h0);
        ack(1'b0, 32'd0);
        fetch(32'h0800_0007, 32'h0, 0, 6'h02, 5'h07, 32'h4);

        // Timeout: TIMEOUT-1 edges still requesting, TIMEOUT-th edge faults
        ack(1'b0, 32'd0);
        wait_req(ok);
        if (!ok) fail_now("tmo_wait_req");
        check("tmo_addr", imem_addr, 32'h4);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_before_fault", {31'd0, fault},    32'd0);
        check("tmo_before_req",   {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check("tmo_fault", {31'd0, fault},    32'd1);
        check("tmo_req",   {31'd0, imem_req}, 32'd0);

        // Misaligned redirect
        do_reset();
        fetch(32'h1111_1111, 32'h0, 0, 6'h04, 5'h11, 32'h4);
        ack(1'b1, 32'h42);
        check("misal_fault",  {31'd0, fault},    32'd1);
        check("misal_req",    {31'd0, imem_req}, 32'd0);
        check("misal_halted", {31'd0, halted},   32'd0);

        // HALT beats a misaligned redirect; no requests afterwards
        do_reset();
        fetch(32'hFC00_0000, 32'h0, 0, 6'h3F, 5'h00, 32'h4);
        ack(1'b1, 32'h42);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_fault",  {31'd0, fault},  32'd0);
        hits = 0;
        imem_valid = 1'b1;
        imem_rdata = 32'h2222_2222;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || instr_valid) hits++;
        end
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        check("halt_no_req_cycles", hits, 32'd0);
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // Reset after HALT resumes fetch at RESET_PC
        do_reset();
        check("resume_addr", imem_addr, 32'h0);
        fetch(32'h2000_0001, 32'h0, 0, 6'h08, 5'h01, 32'h4);
        ack(1'b1, 32'h80);
        fetch(32'h0C00_0002, 32'h80, 0, 6'h03, 5'h02, 32'h84);
        ack(1'b0, 32'd0);
        wait_req(ok);
        if (!ok) fail_now("midreq_wait_req");
        check("midreq_addr", imem_addr, 32'h84);

        // Asynchronous reset in the middle of a request cycle
        #2;
        rst = 1'b1;
        #1;
        check("async_req",    {31'd0, imem_req},    32'd0);
        check("async_addr",   imem_addr,            32'h0);
        check("async_pc_out", pc_out,               32'h0);
        check("async_pc4",    pc_plus4,             32'h0);
        check("async_opcode", {26'd0, opcode},      32'd0);
        check("async_valid",  {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
